// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-drive signals of the 8-bit ALU sequencer.
// The master side issues requests and supplies the ALU result.
interface alu_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_y;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_y;
   logic       rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b,
      output rsp_ready, alu_y,
      input  req_ready, alu_sel, alu_a, alu_b,
      input  rsp_valid, rsp_y, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      input  rsp_ready, alu_y,
      output req_ready, alu_sel, alu_a, alu_b,
      output rsp_valid, rsp_y, rsp_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// Single-issue sequencer for the 8-bit ALU bank.
// Runs direct ops in one cycle and MUL as eight shift-add cycles.
module alu_sequencer (
   input  logic           clk,
   input  logic           rst_n,
   alu_sequencer_if.slave bus,
   output logic           busy,
   output logic [15:0]    done_cnt
);
   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] op_r;
   logic [7:0] a_r;
   logic [7:0] b_r;
   logic [7:0] acc;
   logic [2:0] cnt;
   logic [7:0] rsp_y_r;
   logic       rsp_err_r;
   logic [3:0] sel;
   logic [7:0] opa;
   logic [7:0] opb;

   always_comb begin
      state_nxt = state;
      sel       = 4'd0;
      opa       = 8'h00;
      opb       = 8'h00;
      unique case (state)
         IDLE: begin
            if (bus.req_valid) begin
               unique case (1'b1)
                  (bus.req_op <= 4'd10): state_nxt = EXEC;
                  (bus.req_op == 4'd11): state_nxt = MUL;
                  default:               state_nxt = RESP;
               endcase
            end
         end
         EXEC: begin
            sel       = op_r;
            opa       = a_r;
            opb       = b_r;
            state_nxt = RESP;
         end
         MUL: begin
            // partial product for bit cnt added onto the accumulator
            sel = 4'd5;
            opa = acc;
            opb = b_r[cnt] ? (a_r << cnt) : 8'h00;
            if (cnt == 3'd7)
               state_nxt = RESP;
         end
         RESP: begin
            if (bus.rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done_cnt  <= 16'h0000;
         op_r      <= 4'd0;
         a_r       <= 8'h00;
         b_r       <= 8'h00;
         acc       <= 8'h00;
         cnt       <= 3'd0;
         rsp_y_r   <= 8'h00;
         rsp_err_r <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_r <= bus.req_op;
                  a_r  <= bus.req_a;
                  b_r  <= bus.req_b;
                  acc  <= 8'h00;
                  cnt  <= 3'd0;
                  if (bus.req_op >= 4'd12) begin
                     rsp_y_r   <= 8'h00;
                     rsp_err_r <= 1'b1;
                  end
               end
            end
            EXEC: begin
               rsp_y_r   <= bus.alu_y;
               rsp_err_r <= 1'b0;
            end
            MUL: begin
               acc <= bus.alu_y;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  rsp_y_r   <= bus.alu_y;
                  rsp_err_r <= 1'b0;
               end
            end
            RESP: begin
               if (bus.rsp_ready)
                  done_cnt <= done_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_y     = rsp_y_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.alu_sel   = sel;
   assign bus.alu_a     = opa;
   assign bus.alu_b     = opb;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU bank model as alu_y source and an
// arithmetic reference model for results, error flag and latency.
module tb_alu_sequencer;
   logic        clk;
   logic        rst_n;
   logic        busy;
   logic [15:0] done_cnt;
   int          n_checks;
   int          n_fail;
   int          exp_done;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .busy     (busy),
      .done_cnt (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU operator bank feeding the 16-way result mux
   always_comb begin
      bus.alu_y = 8'h00;
      case (bus.alu_sel)
         4'd0:  bus.alu_y = ~bus.alu_a;
         4'd1:  bus.alu_y = ~bus.alu_b;
         4'd2:  bus.alu_y = bus.alu_a | bus.alu_b;
         4'd3:  bus.alu_y = bus.alu_a & bus.alu_b;
         4'd4:  bus.alu_y = bus.alu_a ^ bus.alu_b;
         4'd5:  bus.alu_y = bus.alu_a + bus.alu_b;
         4'd6:  bus.alu_y = bus.alu_a << bus.alu_b[2:0];
         4'd7:  bus.alu_y = bus.alu_a >> bus.alu_b[2:0];
         4'd8:  bus.alu_y = $signed(bus.alu_a) >>> bus.alu_b[2:0];
         4'd9:  bus.alu_y = 8'(({bus.alu_a, bus.alu_a} << bus.alu_b[2:0]) >> 8);
         4'd10: bus.alu_y = 8'({bus.alu_a, bus.alu_a} >> bus.alu_b[2:0]);
         default: bus.alu_y = 8'h00;
      endcase
   end

   function automatic int model_y(input int op, input int a, input int b);
      int s;
      int r;
      s = b % 8;
      r = 0;
      case (op)
         0:  r = 255 - a;
         1:  r = 255 - b;
         2:  r = a | b;
         3:  r = a & b;
         4:  r = a ^ b;
         5:  r = (a + b) % 256;
         6:  r = (a * (1 << s)) % 256;
         7:  r = a / (1 << s);
         8: begin
            r = (a >= 128) ? a - 256 : a;
            for (int i = 0; i < s; i++)
               r = (r < 0) ? (r - 1) / 2 : r / 2;
            r = r & 255;
         end
         9: begin
            r = a;
            for (int i = 0; i < s; i++)
               r = (r * 2) % 256 + r / 128;
         end
         10: begin
            r = a;
            for (int i = 0; i < s; i++)
               r = r / 2 + (r % 2) * 128;
         end
         11: r = (a * b) % 256;
         default: r = 0;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input int op);
      if (op <= 10) return 1;
      if (op == 11) return 8;
      return 0;
   endfunction

   // issue one request; return at the first cycle rsp_valid is seen
   task automatic send(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int lat);
      int k;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      k = 0;
      while (!bus.req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'($urandom);
      bus.req_a     = 8'($urandom);
      bus.req_b     = 8'($urandom);
      lat = 0;
      while (!bus.rsp_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      exp_done++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({bus.rsp_valid, bus.req_ready, busy, bus.rsp_err} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_ctrl: got v/rdy/busy/err=%b want 0100",
                  {bus.rsp_valid, bus.req_ready, busy, bus.rsp_err});
      end
      n_checks++;
      if ({bus.rsp_y, done_cnt, bus.alu_sel, bus.alu_a, bus.alu_b} !== 44'h0) begin
         n_fail++;
         $display("FAIL reset_data: got y=%h done=%h sel=%h a=%h b=%h want all 0",
                  bus.rsp_y, done_cnt, bus.alu_sel, bus.alu_a, bus.alu_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_done = 0;
   endtask

   task automatic run_one(input string name, input int op, input int a,
                          input int b, input int stall);
      int lat;
      int ey;
      int el;
      logic [7:0] y0;
      ey = model_y(op, a, b);
      el = model_lat(op);
      send(4'(op), 8'(a), 8'(b), lat);
      n_checks++;
      if (lat != el) begin
         n_fail++;
         $display("FAIL %s_lat: op=%0d got %0d want %0d", name, op, lat, el);
      end
      n_checks++;
      if (bus.rsp_y !== 8'(ey) || bus.rsp_err !== (op >= 12)) begin
         n_fail++;
         $display("FAIL %s_y: op=%0d a=%h b=%h got y=%h err=%b want y=%h err=%b",
                  name, op, a, b, bus.rsp_y, bus.rsp_err, 8'(ey), op >= 12);
      end
      y0 = bus.rsp_y;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         n_checks++;
         if (!bus.rsp_valid || bus.req_ready || !busy || bus.rsp_y !== y0
             || done_cnt !== 16'(exp_done)) begin
            n_fail++;
            $display("FAIL %s_hold: v=%b rdy=%b busy=%b y=%h done=%0d want 1 0 1 %h %0d",
                     name, bus.rsp_valid, bus.req_ready, busy, bus.rsp_y,
                     done_cnt, y0, exp_done);
         end
      end
      consume();
      n_checks++;
      if (done_cnt !== 16'(exp_done) || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done: got cnt=%0d v=%b want cnt=%0d v=0",
                  name, done_cnt, bus.rsp_valid, exp_done);
      end
   endtask

   task automatic test_direct();
      run_one("add", 5, 8'h7F, 8'h01, 0);
      run_one("rol", 9, 8'h81, 8'h01, 0);
      for (int i = 0; i < 11; i++)
         run_one("direct", i, $urandom_range(255), $urandom_range(255), 0);
   endtask

   task automatic test_mul();
      run_one("mul13x11", 11, 13, 11, 0);
      run_one("mul10x10", 11, 8'h10, 8'h10, 0);
      run_one("mulffxff", 11, 8'hFF, 8'hFF, 0);
      for (int i = 0; i < 5; i++)
         run_one("mul_rand", 11, $urandom_range(255), $urandom_range(255), 0);
   endtask

   task automatic test_illegal();
      run_one("illegal", 12, 8'h55, 8'hAA, 0);
      run_one("illegal15", 15, 8'h12, 8'h34, 1);
   endtask

   task automatic test_backpressure();
      run_one("asr_bp", 8, 8'h80, 8'h03, 5);
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd11;
      bus.req_a     = 8'd7;
      bus.req_b     = 8'd9;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_done = 0;
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 16'h0
          || bus.req_ready !== 1'b1 || bus.alu_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_mid_mul: v=%b busy=%b done=%0d rdy=%b sel=%0d want 0 0 0 1 0",
                  bus.rsp_valid, busy, done_cnt, bus.req_ready, bus.alu_sel);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         n_checks++;
         if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_rsp: got rsp_valid=%b want 0", bus.rsp_valid);
         end
      end
      run_one("add_after_rst", 5, 8'h01, 8'h02, 0);
      lat = 0;
   endtask

   task automatic test_back_to_back();
      int ops[3];
      int as[3];
      int bs[3];
      int idx;
      int got;
      int cyc;
      int ey;
      ops = '{5, 11, 4};
      for (int i = 0; i < 3; i++) begin
         as[i] = $urandom_range(255);
         bs[i] = $urandom_range(255);
      end
      idx = 0;
      got = 0;
      cyc = 0;
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      while (got < 3 && cyc < 100) begin
         bus.req_valid = (idx < 3);
         if (idx < 3) begin
            bus.req_op = 4'(ops[idx]);
            bus.req_a  = 8'(as[idx]);
            bus.req_b  = 8'(bs[idx]);
         end
         #1;
         n_checks++;
         if (bus.req_ready && (busy || bus.rsp_valid)) begin
            n_fail++;
            $display("FAIL b2b_ready: rdy=1 with busy=%b rsp_valid=%b want 0 0",
                     busy, bus.rsp_valid);
         end
         if (bus.req_valid && bus.req_ready)
            idx++;
         if (bus.rsp_valid) begin
            ey = model_y(ops[got], as[got], bs[got]);
            n_checks++;
            if (bus.rsp_y !== 8'(ey) || bus.rsp_err !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_rsp%0d: got y=%h err=%b want y=%h err=0",
                        got, bus.rsp_y, bus.rsp_err, 8'(ey));
            end
            got++;
            exp_done++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      n_checks++;
      if (got != 3 || done_cnt !== 16'(exp_done)) begin
         n_fail++;
         $display("FAIL b2b_count: got rsp=%0d done=%0d want rsp=3 done=%0d",
                  got, done_cnt, exp_done);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++)
         run_one("rand", $urandom_range(15), $urandom_range(255),
                 $urandom_range(255), $urandom_range(3));
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      exp_done      = 0;
      rst_n         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'd0;
      bus.req_a     = 8'h00;
      bus.req_b     = 8'h00;
      bus.rsp_ready = 1'b0;
      #1;
      test_reset();
      test_direct();
      test_mul();
      test_illegal();
      test_backpressure();
      test_reset_mid_mul();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
